// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-requester shared-memory bus bundle
interface mem_arbiter_if;
  logic        m0_req;
  logic        m0_lock;
  logic [31:0] m0_addr;
  logic        m0_wr_ena;
  logic [31:0] m0_wr_data;
  logic        m0_gnt;
  logic        m0_rd_valid;
  logic [31:0] m0_rd_data;

  logic        m1_req;
  logic        m1_lock;
  logic [31:0] m1_addr;
  logic        m1_wr_ena;
  logic [31:0] m1_wr_data;
  logic        m1_gnt;
  logic        m1_rd_valid;
  logic [31:0] m1_rd_data;

  logic [31:0] mem_addr;
  logic        mem_wr_ena;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_wr_ena, m0_wr_data,
    output m0_gnt, m0_rd_valid, m0_rd_data,
    input  m1_req, m1_lock, m1_addr, m1_wr_ena, m1_wr_data,
    output m1_gnt, m1_rd_valid, m1_rd_data,
    output mem_addr, mem_wr_ena, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output m0_req, m0_lock, m0_addr, m0_wr_ena, m0_wr_data,
    input  m0_gnt, m0_rd_valid, m0_rd_data,
    output m1_req, m1_lock, m1_addr, m1_wr_ena, m1_wr_data,
    input  m1_gnt, m1_rd_valid, m1_rd_data,
    input  mem_addr, mem_wr_ena, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU / loader arbiter for a single-port memory with lockable grants
module mem_arbiter #(
  parameter int MAX_LOCK = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_LOCK) + 1;
  localparam logic [CW-1:0] LOCK_LIMIT = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_tag_q, rd_tag_d;

  logic        own_any;
  logic        own_id;
  logic        own_req;
  logic        own_lock;
  logic        own_wr;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic        oth_req;
  logic        xfer;
  logic        active;

  // Present the current owner's signals as a single view so both OWN states share logic.
  always_comb begin
    own_any   = (state_q == OWN0) || (state_q == OWN1);
    own_id    = (state_q == OWN1);
    own_req   = own_id ? bus.m1_req     : bus.m0_req;
    own_lock  = own_id ? bus.m1_lock    : bus.m0_lock;
    own_wr    = own_id ? bus.m1_wr_ena  : bus.m0_wr_ena;
    own_addr  = own_id ? bus.m1_addr    : bus.m0_addr;
    own_wdata = own_id ? bus.m1_wr_data : bus.m0_wr_data;
    oth_req   = own_id ? bus.m0_req     : bus.m1_req;
    xfer      = own_any && own_req;
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;
    rd_pend_d  = xfer && !own_wr;
    rd_tag_d   = own_id;

    case (state_q)
      IDLE: begin
        lock_cnt_d = '0;
        if (bus.m0_req && bus.m1_req) begin
          state_d = prio_q ? OWN1 : OWN0;
        end else if (bus.m0_req) begin
          state_d = OWN0;
        end else if (bus.m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (xfer) begin
          prio_d = !own_id;
        end
        // Locked stay is capped so the other requester cannot be starved forever.
        if (own_req && own_lock && (lock_cnt_q < LOCK_LIMIT)) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else if (oth_req) begin
          state_d    = own_id ? OWN0 : OWN1;
          lock_cnt_d = '0;
        end else if (own_req) begin
          lock_cnt_d = '0;
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  // Outputs are forced quiet while rst is high so nothing leaks from pre-reset state.
  always_comb begin
    active          = !rst;
    bus.m0_gnt      = active && (state_q == OWN0);
    bus.m1_gnt      = active && (state_q == OWN1);
    bus.mem_addr    = (active && xfer) ? own_addr : 32'd0;
    bus.mem_wr_data = (active && xfer) ? own_wdata : 32'd0;
    bus.mem_wr_ena  = active && xfer && own_wr;
    bus.m0_rd_valid = active && rd_pend_q && !rd_tag_q;
    bus.m1_rd_valid = active && rd_pend_q && rd_tag_q;
    bus.m0_rd_data  = bus.mem_rd_data;
    bus.m1_rd_data  = bus.mem_rd_data;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst;
  logic dev_init;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_LOCK(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Memory device behind the arbiter: one-cycle read latency.
  logic [31:0] dev_mem [256];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (dev_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= pat(i);
    end else if (bus.mem_wr_ena) begin
      dev_mem[bus.mem_addr[7:0]] <= bus.mem_wr_data;
    end
    rd_q <= dev_mem[bus.mem_addr[7:0]];
  end
  assign bus.mem_rd_data = rd_q;

  int checks = 0;
  int failures = 0;

  logic        i_req [2];
  logic        i_lock [2];
  logic        i_wr [2];
  logic [31:0] i_addr [2];
  logic [31:0] i_wd [2];

  // Behavioural model: owner -1 = nobody, 0/1 = requester.
  int          m_own;
  int          m_prio;
  int          m_run;
  int          m_pend;
  logic [31:0] m_pdata;
  logic [31:0] ref_mem [256];

  logic        o_g0, o_g1, o_rv0, o_rv1, o_wena;
  logic [31:0] o_rd, o_addr;
  int          txq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic l0, input logic w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic l1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    i_req[0] = r0; i_lock[0] = l0; i_wr[0] = w0; i_addr[0] = a0; i_wd[0] = d0;
    i_req[1] = r1; i_lock[1] = l1; i_wr[1] = w1; i_addr[1] = a1; i_wd[1] = d1;
    bus.m0_req = r0; bus.m0_lock = l0; bus.m0_wr_ena = w0; bus.m0_addr = a0; bus.m0_wr_data = d0;
    bus.m1_req = r1; bus.m1_lock = l1; bus.m1_wr_ena = w1; bus.m1_addr = a1; bus.m1_wr_data = d1;
  endtask

  task automatic model_edge();
    int x;
    int o;
    x = m_own;
    if (rst) begin
      m_own = -1; m_prio = 0; m_run = 0; m_pend = -1;
      return;
    end
    m_pend = -1;
    if (x < 0) begin
      m_run = 0;
      if (i_req[0] && i_req[1]) m_own = m_prio;
      else if (i_req[0]) m_own = 0;
      else if (i_req[1]) m_own = 1;
      return;
    end
    o = 1 - x;
    if (i_req[x]) begin
      if (i_wr[x]) ref_mem[i_addr[x][7:0]] = i_wd[x];
      else begin
        m_pend  = x;
        m_pdata = ref_mem[i_addr[x][7:0]];
      end
      m_prio = o;
    end
    if (i_req[x] && i_lock[x] && m_run < ML - 1) m_run++;
    else if (i_req[o]) begin m_own = o; m_run = 0; end
    else if (i_req[x]) m_run = 0;
    else begin m_own = -1; m_run = 0; end
  endtask

  task automatic step();
    logic        ex;
    logic [31:0] e_addr, e_wd;
    logic        e_wena;
    #1;
    ex     = !rst && m_own >= 0 && i_req[m_own];
    e_addr = ex ? i_addr[m_own] : 32'd0;
    e_wd   = ex ? i_wd[m_own] : 32'd0;
    e_wena = ex && i_wr[m_own];
    o_g0 = bus.m0_gnt; o_g1 = bus.m1_gnt;
    o_rv0 = bus.m0_rd_valid; o_rv1 = bus.m1_rd_valid;
    o_wena = bus.mem_wr_ena; o_addr = bus.mem_addr;
    o_rd = o_rv0 ? bus.m0_rd_data : bus.m1_rd_data;
    chk("m0_gnt", 32'(o_g0), 32'(!rst && m_own == 0));
    chk("m1_gnt", 32'(o_g1), 32'(!rst && m_own == 1));
    chk("mem_addr", o_addr, e_addr);
    chk("mem_wr_data", bus.mem_wr_data, e_wd);
    chk("mem_wr_ena", 32'(o_wena), 32'(e_wena));
    chk("m0_rd_valid", 32'(o_rv0), 32'(!rst && m_pend == 0));
    chk("m1_rd_valid", 32'(o_rv1), 32'(!rst && m_pend == 1));
    if (!rst && m_pend >= 0) chk("rd_data", o_rd, m_pdata);
    if (o_g0 && i_req[0]) txq.push_back(0);
    if (o_g1 && i_req[1]) txq.push_back(1);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_drive();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle_drive();
    for (int k = 0; k < n; k++) step();
    rst = 1'b0;
  endtask

  int cnt_g1;
  int seen_rv0;
  logic [31:0] got;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    m_own = -1; m_prio = 0; m_run = 0; m_pend = -1; m_pdata = '0;
    dev_init = 1'b1;
    rst = 1'b1;
    idle_drive();
    step();
    dev_init = 1'b0;
    do_reset(4);

    // First access from idle: grant one cycle after request, data the cycle after.
    drive(1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    step();
    chk("req029_gnt_latency", 32'(o_g0), 32'd0);
    step();
    chk("req029_gnt", 32'(o_g0), 32'd1);
    chk("req029_addr", o_addr, 32'h10);
    idle_drive();
    step();
    chk("req029_rv", 32'(o_rv0), 32'd1);
    chk("req029_data", o_rd, pat(16));

    // Contention without lock alternates starting with requester 0.
    do_reset(1);
    txq.delete();
    drive(1, 0, 0, 32'h01, 0, 1, 0, 0, 32'h02, 0);
    for (int k = 0; k < 5; k++) step();
    idle_drive();
    step();
    chk("req030_count", 32'(txq.size()), 32'd4);
    for (int k = 0; k < 4 && k < txq.size(); k++)
      chk("req030_order", 32'(txq[k]), 32'(k % 2));

    // Locked requester 1 keeps the bus exactly MAX_LOCK cycles.
    do_reset(1);
    cnt_g1 = 0;
    drive(0, 0, 0, 0, 0, 1, 1, 0, 32'h03, 0);
    step();
    drive(1, 0, 0, 32'h04, 0, 1, 1, 0, 32'h03, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_g1) cnt_g1++;
    end
    chk("req031_lock_cycles", 32'(cnt_g1), 32'(ML));
    chk("req031_handoff", 32'(o_g0), 32'd1);
    idle_drive();
    step();

    // Write by requester 0 is visible to a later read by requester 1.
    do_reset(1);
    seen_rv0 = 0;
    got = '0;
    drive(1, 0, 1, 32'h20, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
    step();
    step();
    idle_drive();
    step();
    if (o_rv1) got = o_rd;
    if (o_rv0) seen_rv0++;
    chk("req032_rv1", 32'(o_rv1), 32'd1);
    chk("req032_data", got, 32'hDEADBEEF);
    chk("req032_no_rv0", 32'(seen_rv0), 32'd0);

    // Reset right after a read issue swallows the return.
    drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h30, 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("req033_rv1", 32'(o_rv1), 32'd0);
    chk("req033_gnt", 32'(o_g1), 32'd0);
    rst = 1'b0;
    idle_drive();
    step();
    chk("req033_idle_gnt", 32'(o_g0 | o_g1), 32'd0);
    chk("req033_idle_addr", o_addr, 32'd0);

    // Granted requester drops req: bus idles, then the arbiter returns to IDLE.
    drive(1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 1, 32'h44, 32'h1234, 0, 0, 0, 0, 0);
    step();
    chk("req034_wena", 32'(o_wena), 32'd0);
    chk("req034_addr", o_addr, 32'd0);
    idle_drive();
    step();
    chk("req034_idle", 32'(o_g0 | o_g1), 32'd0);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
            32'($urandom_range(0, 255)), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
            32'($urandom_range(0, 255)), $urandom);
      step();
    end
    rst = 1'b0;
    idle_drive();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_LOCK, default 16, maximum consecutive cycles one requester may hold a locked grant.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Ports for requester x (x = 0 = CPU, 1 = loader/debug): mx_req in 1; mx_lock in 1; mx_addr in 32; mx_wr_ena in 1; mx_wr_data in 32.
REQ-005 Ports for requester x: mx_gnt out 1 (x owns memory bus this cycle); mx_rd_valid out 1; mx_rd_data out 32.
REQ-006 Port: mem_addr  output  32  shared memory address.
REQ-007 Port: mem_wr_ena  output  1  shared memory write enable.
REQ-008 Port: mem_wr_data  output  32  shared memory write data.
REQ-009 Port: mem_rd_data  input  32  memory read data, valid one cycle after address presented.

Function
REQ-010 FSM states IDLE, OWN0, OWN1; mx_gnt = (state == OWNx), Moore, no combinational path from req to gnt.
REQ-011 Transaction: cycle with mx_gnt=1 and mx_req=1; read if mx_wr_ena=0, write if 1.
REQ-012 In OWNx, mem_addr/mem_wr_data driven from mx_addr/mx_wr_data; mem_wr_ena = mx_wr_ena & mx_req.
REQ-013 In IDLE, or OWNx with mx_req=0: mem_addr=0, mem_wr_data=0, mem_wr_ena=0.
REQ-014 IDLE: no req -> IDLE; one req -> OWN of that requester; both -> OWN of requester named by prio.
REQ-015 prio 1-bit; set to the other requester whenever a transaction by requester x completes.
REQ-016 OWNx next state, first match: (a) mx_req & mx_lock & lock_cnt < MAX_LOCK-1 -> OWNx; (b) other req -> OWNother; (c) mx_req -> OWNx; (d) -> IDLE.
REQ-017 Consequence: unlocked requesters alternate every transaction under contention; direct OWN0<->OWN1 hand-off, no IDLE bubble.
REQ-018 lock_cnt increments each OWNx cycle in which rule (a) taken; clears on any state change or rule (c) stay.
REQ-019 lock_cnt saturation forces release via rule (b)/(c)/(d) ordering; width = clog2(MAX_LOCK)+1.
REQ-020 First access latency from IDLE: gnt asserted cycle N+1 after req seen at edge N.
REQ-021 Read return: mx_rd_valid=1 exactly one cycle after a read transaction of x; registered tag selects x.
REQ-022 mx_rd_data = mem_rd_data for both requesters; meaningful only when mx_rd_valid=1.
REQ-023 Writes produce no rd_valid; m0_rd_valid and m1_rd_valid never high together.
REQ-024 Requester dropping mx_req while granted: no transaction that cycle, bus idle values per REQ-013.

Reset
REQ-025 rst=1 at an edge: state=IDLE, prio=0, lock_cnt=0, rd tag cleared.
REQ-026 During and after reset cycle: m0_gnt=m1_gnt=0, m0_rd_valid=m1_rd_valid=0, mem_wr_ena=0, mem_addr=0, mem_wr_data=0.
REQ-027 Reset mid-operation: read issued in the cycle before rst edge yields no rd_valid; locked ownership lost.
REQ-028 No behaviour depends on input values while rst=1.

Verification
REQ-029 Reset 5 cycles, then m0_req=1 read addr 0x10 -> m0_gnt cycle+1, mem_addr=0x10, m0_rd_valid next cycle with memory word.
REQ-030 Both req from IDLE after reset, no lock -> order M0,M1,M0,M1; one transaction each; gnt never overlaps.
REQ-031 m1_lock=1, m1_req held, m0_req=1, MAX_LOCK=4 -> M1 owns exactly 4 cycles, then M0 granted.
REQ-032 M0 write 0xDEADBEEF to 0x20, then M1 read 0x20 -> m1_rd_valid with 0xDEADBEEF, m0_rd_valid stays 0.
REQ-033 rst asserted one cycle after M1 read issue -> m1_rd_valid stays 0, all outputs zero, state IDLE.
REQ-034 m0 granted, m0_req drops for one cycle, m1 idle -> mem_wr_ena=0 that cycle; next cycle IDLE.
